oled_spi_streamer: RTL and testbench

Serializes one 1024-byte frame (`imagem`, 128×64 monochrome, SSD1306 page layout) onto a write-only 4-wire SPI link to the OLED panel. Sits directly downstream of the image controller: on `iniciar` it snapshots the 8192-bit image and sends a fixed 6-byte addressing preamble as commands. It then sends the 1024 bytes as display data and pulses `quadro_feito` when the frame is complete.

---
 rtl/oled_spi_streamer.sv | 129 ++++++++++++
 tb/tb_oled_spi_streamer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_streamer.sv
// Streams a snapshotted 128x64 SSD1306 frame over 4-wire SPI (mode 0, MSB first):
// a 6-byte addressing preamble as commands, then 1024 data bytes, then a done pulse.
module oled_spi_streamer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [8191:0] imagem,
    input  logic          iniciar,
    output logic          ocupado,
    output logic          quadro_feito,
    output logic          spi_sclk,
    output logic          spi_mosi,
    output logic          spi_cs_n,
    output logic          spi_dc
);

    localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {StOcioso, StComando, StDados, StFim} state_e;

    state_e          state_q, state_d;
    logic [8191:0]   snap_q, snap_d;
    logic [9:0]      byte_q, byte_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      div_q, div_d;
    logic [7:0]      shift_q, shift_d;
    logic            sclk_q, sclk_d;
    logic            active;

    // Column range 0..127, page range 0..7.
    function automatic logic [7:0] preamble(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h21;
            3'd1:    return 8'h00;
            3'd2:    return 8'h7F;
            3'd3:    return 8'h22;
            3'd4:    return 8'h00;
            3'd5:    return 8'h07;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        div_d   = div_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        case (state_q)
            StOcioso: begin
                if (iniciar) begin
                    state_d = StComando;
                    snap_d  = imagem;
                    byte_d  = '0;
                    bit_d   = '0;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    shift_d = preamble(3'd0);
                end
            end
            StComando, StDados: begin
                if (div_q == DivMax) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Falling edge closes the bit; next bit is presented while sclk is low.
                    if (sclk_q) begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                        if (bit_q == 3'd7) begin
                            byte_d = byte_q + 10'd1;
                            if (state_q == StComando) begin
                                if (byte_q == 10'd5) begin
                                    state_d = StDados;
                                    byte_d  = '0;
                                    shift_d = snap_q[7:0];
                                    snap_d  = snap_q >> 8;
                                end else begin
                                    shift_d = preamble(byte_q[2:0] + 3'd1);
                                end
                            end else begin
                                shift_d = snap_q[7:0];
                                snap_d  = snap_q >> 8;
                                if (byte_q == 10'd1023) begin
                                    state_d = StFim;
                                end
                            end
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StFim:   state_d = StOcioso;
            default: state_d = StOcioso;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StOcioso;
            snap_q  <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
        end
    end

    assign active       = (state_q == StComando) || (state_q == StDados);
    assign ocupado      = active;
    assign spi_cs_n     = ~active;
    assign quadro_feito = (state_q == StFim);
    assign spi_sclk     = sclk_q;
    assign spi_mosi     = active & shift_q[7];
    assign spi_dc       = (state_q == StDados);

endmodule

// File: tb/tb_oled_spi_streamer.sv
// Directed bench: two instances (CLK_DIV=2 and CLK_DIV=1) observed by an SPI slave model
// that rebuilds bytes on sclk rising edges and measures chip-select windows.
module tb_oled_spi_streamer;

    localparam int Frame = 1030;

    logic          clk = 1'b0;
    logic          rst;
    logic [8191:0] imagem;
    logic [8191:0] pattern;
    logic [1:0]    iniciar;
    logic [1:0]    ocupado, qf, sclk, mosi, cs_n, dc;
    logic          clr;

    int tests = 0;
    int fails = 0;

    logic [7:0] pre [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    logic [7:0] cap   [2][2*Frame];
    logic       capdc [2][2*Frame];
    logic [7:0] sh    [2];
    logic       prev  [2];
    int         n     [2];
    int         bits  [2];
    int         run   [2];
    int         lens  [2][4];
    int         nl    [2];
    int         qf_cnt[2];
    int         qf_bad[2];

    always #5 clk = ~clk;

    oled_spi_streamer #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .imagem(imagem), .iniciar(iniciar[0]),
        .ocupado(ocupado[0]), .quadro_feito(qf[0]), .spi_sclk(sclk[0]),
        .spi_mosi(mosi[0]), .spi_cs_n(cs_n[0]), .spi_dc(dc[0])
    );

    oled_spi_streamer #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .imagem(imagem), .iniciar(iniciar[1]),
        .ocupado(ocupado[1]), .quadro_feito(qf[1]), .spi_sclk(sclk[1]),
        .spi_mosi(mosi[1]), .spi_cs_n(cs_n[1]), .spi_dc(dc[1])
    );

    // Slave model: values seen at a clk edge are those of the cycle just ending.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                n[k]      <= 0;
                bits[k]   <= 0;
                run[k]    <= 0;
                nl[k]     <= 0;
                qf_cnt[k] <= 0;
                qf_bad[k] <= 0;
                prev[k]   <= sclk[k];
            end else begin
                prev[k] <= sclk[k];
                if (sclk[k] === 1'b1 && prev[k] === 1'b0) begin
                    sh[k] <= {sh[k][6:0], mosi[k]};
                    if (bits[k] == 7) begin
                        bits[k] <= 0;
                        if (n[k] < 2*Frame) begin
                            cap[k][n[k]]   <= {sh[k][6:0], mosi[k]};
                            capdc[k][n[k]] <= dc[k];
                        end
                        n[k] <= n[k] + 1;
                    end else begin
                        bits[k] <= bits[k] + 1;
                    end
                end
                if (cs_n[k] === 1'b0) begin
                    run[k] <= run[k] + 1;
                end else if (run[k] != 0) begin
                    if (nl[k] < 4) lens[k][nl[k]] <= run[k];
                    nl[k]  <= nl[k] + 1;
                    run[k] <= 0;
                end
                if (qf[k] === 1'b1) begin
                    qf_cnt[k] <= qf_cnt[k] + 1;
                    if (ocupado[k] !== 1'b0 || cs_n[k] !== 1'b1 || sclk[k] !== 1'b0)
                        qf_bad[k] <= qf_bad[k] + 1;
                end
            end
        end
    end

    function automatic int frame_bad(input int k, input int base);
        int         bad;
        logic [7:0] exp_b;
        logic       exp_dc;
        bad = 0;
        for (int j = 0; j < Frame; j++) begin
            if (j < 6) begin
                exp_b  = pre[j];
                exp_dc = 1'b0;
            end else begin
                exp_b  = 8'((j - 6) % 256);
                exp_dc = 1'b1;
            end
            if (cap[k][base+j] !== exp_b || capdc[k][base+j] !== exp_dc) bad++;
        end
        return bad;
    endfunction

    task automatic clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Returns at the negedge of cycle S+1.
    task automatic start(input int k);
        @(negedge clk);
        iniciar[k] = 1'b1;
        @(negedge clk);
        iniciar[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int c;
        c = 0;
        while (ocupado[k] !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (ocupado[k] !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle[%0d]: ocupado=%b after %0d cycles, required 0", k,
                     ocupado[k], budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++; if (sclk[k] !== 1'b0) begin fails++; $display("FAIL reset_sclk[%0d]: got %b want 0", k, sclk[k]); end
            tests++; if (mosi[k] !== 1'b0) begin fails++; $display("FAIL reset_mosi[%0d]: got %b want 0", k, mosi[k]); end
            tests++; if (cs_n[k] !== 1'b1) begin fails++; $display("FAIL reset_cs_n[%0d]: got %b want 1", k, cs_n[k]); end
            tests++; if (dc[k] !== 1'b0) begin fails++; $display("FAIL reset_dc[%0d]: got %b want 0", k, dc[k]); end
            tests++; if (ocupado[k] !== 1'b0) begin fails++; $display("FAIL reset_ocupado[%0d]: got %b want 0", k, ocupado[k]); end
            tests++; if (qf[k] !== 1'b0) begin fails++; $display("FAIL reset_qf[%0d]: got %b want 0", k, qf[k]); end
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // CLK_DIV=2 frame; imagem is overwritten at S+100 to check the snapshot.
    task automatic test_full_frame();
        clear();
        start(0);
        tests++; if (ocupado[0] !== 1'b1) begin fails++; $display("FAIL s1_ocupado: got %b want 1", ocupado[0]); end
        tests++; if (cs_n[0] !== 1'b0) begin fails++; $display("FAIL s1_cs_n: got %b want 0", cs_n[0]); end
        tests++; if (dc[0] !== 1'b0) begin fails++; $display("FAIL s1_dc: got %b want 0", dc[0]); end
        tests++; if (mosi[0] !== 1'b0) begin fails++; $display("FAIL s1_mosi: got %b want 0", mosi[0]); end
        tests++; if (sclk[0] !== 1'b0) begin fails++; $display("FAIL s1_sclk: got %b want 0", sclk[0]); end
        @(negedge clk);
        tests++; if (sclk[0] !== 1'b0) begin fails++; $display("FAIL s2_sclk: got %b want 0", sclk[0]); end
        @(negedge clk);
        tests++; if (sclk[0] !== 1'b1) begin fails++; $display("FAIL s3_sclk_rise: got %b want 1", sclk[0]); end
        repeat (97) @(negedge clk);
        imagem = {8192{1'b1}};
        wait_idle(0, 40000);
        imagem = pattern;
        tests++; if (n[0] !== Frame) begin fails++; $display("FAIL ff_byte_count: got %0d want %0d", n[0], Frame); end
        for (int j = 0; j < 6; j++) begin
            tests++;
            if (cap[0][j] !== pre[j] || capdc[0][j] !== 1'b0) begin
                fails++;
                $display("FAIL ff_cmd%0d: got %h dc=%b want %h dc=0", j, cap[0][j], capdc[0][j], pre[j]);
            end
        end
        tests++; if (frame_bad(0, 0) != 0) begin fails++; $display("FAIL ff_frame: %0d bad bytes, want 0", frame_bad(0, 0)); end
        tests++; if (nl[0] !== 1) begin fails++; $display("FAIL ff_cs_windows: got %0d want 1", nl[0]); end
        tests++; if (lens[0][0] !== 32960) begin fails++; $display("FAIL ff_cs_len: got %0d want 32960", lens[0][0]); end
        tests++; if (qf_cnt[0] !== 1) begin fails++; $display("FAIL ff_qf_count: got %0d want 1", qf_cnt[0]); end
        tests++; if (qf_bad[0] !== 0) begin fails++; $display("FAIL ff_qf_cycle: got %0d bad want 0", qf_bad[0]); end
    endtask

    task automatic test_reset_mid_frame();
        clear();
        start(1);
        repeat (4999) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++; if (cs_n[1] !== 1'b1) begin fails++; $display("FAIL mid_cs_n: got %b want 1", cs_n[1]); end
        tests++; if (sclk[1] !== 1'b0) begin fails++; $display("FAIL mid_sclk: got %b want 0", sclk[1]); end
        tests++; if (ocupado[1] !== 1'b0) begin fails++; $display("FAIL mid_ocupado: got %b want 0", ocupado[1]); end
        repeat (20) @(negedge clk);
        tests++; if (qf_cnt[1] !== 0) begin fails++; $display("FAIL mid_no_qf: got %0d want 0", qf_cnt[1]); end
        rst = 1'b0;
    endtask

    // Restart after the aborted frame, busy requests ignored, then an immediate second frame.
    task automatic test_back_to_back();
        int c;
        clear();
        start(1);
        tests++; if (cs_n[1] !== 1'b0) begin fails++; $display("FAIL b2b_start_cs_n: got %b want 0", cs_n[1]); end
        for (int p = 0; p < 10; p++) begin
            repeat (300) @(negedge clk);
            iniciar[1] = 1'b1;
            @(negedge clk);
            iniciar[1] = 1'b0;
        end
        c = 0;
        while (qf[1] !== 1'b1 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        tests++; if (qf[1] !== 1'b1) begin fails++; $display("FAIL b2b_wait_qf: got %b want 1", qf[1]); end
        @(negedge clk);
        iniciar[1] = 1'b1;
        tests++; if (ocupado[1] !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: got %b want 0", ocupado[1]); end
        @(negedge clk);
        iniciar[1] = 1'b0;
        tests++; if (ocupado[1] !== 1'b1 || cs_n[1] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second_start: ocupado=%b cs_n=%b want 1 0", ocupado[1], cs_n[1]);
        end
        wait_idle(1, 20000);
        repeat (100) @(negedge clk);
        tests++; if (cs_n[1] !== 1'b1) begin fails++; $display("FAIL b2b_cs_idle: got %b want 1", cs_n[1]); end
        tests++; if (n[1] !== 2*Frame) begin fails++; $display("FAIL b2b_byte_count: got %0d want %0d", n[1], 2*Frame); end
        tests++; if (frame_bad(1, 0) != 0) begin fails++; $display("FAIL b2b_frame0: %0d bad bytes, want 0", frame_bad(1, 0)); end
        tests++; if (frame_bad(1, Frame) != 0) begin fails++; $display("FAIL b2b_frame1: %0d bad bytes, want 0", frame_bad(1, Frame)); end
        tests++; if (nl[1] !== 2) begin fails++; $display("FAIL b2b_cs_windows: got %0d want 2", nl[1]); end
        tests++; if (lens[1][0] !== 16480) begin fails++; $display("FAIL b2b_cs_len0: got %0d want 16480", lens[1][0]); end
        tests++; if (lens[1][1] !== 16480) begin fails++; $display("FAIL b2b_cs_len1: got %0d want 16480", lens[1][1]); end
        tests++; if (qf_cnt[1] !== 2) begin fails++; $display("FAIL b2b_qf_count: got %0d want 2", qf_cnt[1]); end
        tests++; if (qf_bad[1] !== 0) begin fails++; $display("FAIL b2b_qf_cycle: got %0d bad want 0", qf_bad[1]); end
    endtask

    initial begin
        rst     = 1'b0;
        iniciar = 2'b00;
        clr     = 1'b0;
        for (int i = 0; i < 1024; i++) pattern[i*8 +: 8] = 8'(i % 256);
        imagem = pattern;
        test_reset();
        test_full_frame();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
